// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer slice.
// Holds the FSM state encoding and its width. The encoding stays as plain
// localparam constants so legacy blocks can compare against the same
// numeric values. A small helper classifies the running states.
// ERR (4) is only reachable when COUNT_SEQ_WATCHDOG_EN is defined.
package count_seq_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_UP     = 3'd1;
  localparam logic [STATE_W-1:0] ST_DOWN   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PAUSED = 3'd3;
  localparam logic [STATE_W-1:0] ST_ERR    = 3'd4;

  // True while a counter is actively counting (not idle, paused or faulted).
  function automatic logic isRunning(input logic [STATE_W-1:0] state);
    return (state == ST_UP) || (state == ST_DOWN);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Phase watchdog for the count sequencer.
// Counts enable cycles (ticks while a counter is running) since the last
// clear. It saturates at WD_TICKS and raises o_expire for as long as it
// sits there. Clear wins over enable, so a fresh start pulse always
// restarts the count from zero.
// Instantiated only when COUNT_SEQ_WATCHDOG_EN is defined.
module seq_watchdog #(
  parameter int WD_TICKS = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int                CNT_W = $clog2(WD_TICKS + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WD_TICKS);

  logic [CNT_W-1:0] r_count;

  // Tick counter: cleared by each start, frozen at the limit so expiry holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expire = (r_count == LIMIT);

endmodule

// File: rtl/count_sequencer.sv
// Central sequencer for the up/down counter pair.
// Takes debounced go and pause pulses. It issues one-cycle start pulses to
// the up and down counters, freezes them while paused, and selects which
// counter drives the LEDs. A run alternates an up phase and a down phase.
// ROUNDS full rounds end the run; ROUNDS = 0 keeps it going until reset.
//
// The internal "pend" bit records a start pulse that a pause swallowed
// (a done and a pause in the same cycle). That start is issued when the
// pause is released.
//
// Optional feature: define COUNT_SEQ_WATCHDOG_EN to add a per-phase tick
// watchdog. If WD_TICKS ticks pass without a done, the FSM enters ERR.
// Without the macro, err is tied low and i_tick is unused.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int ROUNDS   = 0,
  parameter int ROUND_W  = 8,
  parameter int WD_TICKS = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tick,
  input  logic               i_go_pulse,
  input  logic               i_pause_pulse,
  input  logic               i_up_done,
  input  logic               i_down_done,
  output logic               o_up_start,
  output logic               o_down_start,
  output logic               o_hold,
  output logic               o_led_sel,
  output logic               o_busy,
  output logic               o_paused,
  output logic [ROUND_W-1:0] o_round_cnt,
  output logic               o_err
);

  localparam logic [ROUND_W-1:0] ROUND_LIMIT    = ROUND_W'(ROUNDS);
  localparam logic               ROUNDS_BOUNDED = (ROUNDS != 0);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_nextState;
  logic               r_phase;
  logic               w_nextPhase;
  logic               r_pend;
  logic               w_nextPend;
  logic [ROUND_W-1:0] r_round;
  logic [ROUND_W-1:0] w_nextRound;
  logic [ROUND_W-1:0] w_roundInc;
  logic               w_finalRound;
  logic               w_upStart;
  logic               w_downStart;
  logic               w_expire;
  logic               w_holdNext;

  // Finishing a down phase bumps the round count (wrapping). The run ends
  // when a bounded run reaches its round limit.
  assign w_roundInc   = r_round + ROUND_W'(1);
  assign w_finalRound = ROUNDS_BOUNDED && (w_roundInc == ROUND_LIMIT);

`ifdef COUNT_SEQ_WATCHDOG_EN
  logic w_wdClear;
  logic w_wdEnable;

  // Restart the phase timer on every start pulse and keep it cleared while
  // idle. It only advances on ticks while a counter is running, so it is
  // frozen in PAUSED.
  assign w_wdClear  = w_upStart | w_downStart | (r_state == ST_IDLE);
  assign w_wdEnable = i_tick & isRunning(r_state);

  seq_watchdog #(
    .WD_TICKS (WD_TICKS)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_wdClear),
    .i_enable (w_wdEnable),
    .o_expire (w_expire)
  );
`else
  logic w_unusedTick;
  localparam int unusedWdTicks = WD_TICKS;

  assign w_unusedTick = i_tick;
  assign w_expire     = 1'b0;
`endif

  // Next-state, bookkeeping and start-pulse decode. A done is always
  // processed before a pause in the same cycle. The pause then only
  // defers the start pulse that the done would have issued.
  always_comb begin
    w_nextState = r_state;
    w_nextPhase = r_phase;
    w_nextPend  = r_pend;
    w_nextRound = r_round;
    w_upStart   = 1'b0;
    w_downStart = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_go_pulse) begin
          w_upStart   = 1'b1;
          w_nextRound = '0;
          w_nextPhase = 1'b1;
          w_nextPend  = 1'b0;
          w_nextState = ST_UP;
        end
      end

      ST_UP: begin
        if (w_expire) begin
          w_nextState = ST_ERR;
        end else if (i_up_done) begin
          w_nextPhase = 1'b0;
          if (i_pause_pulse) begin
            w_nextPend  = 1'b1;
            w_nextState = ST_PAUSED;
          end else begin
            w_downStart = 1'b1;
            w_nextState = ST_DOWN;
          end
        end else if (i_pause_pulse) begin
          w_nextState = ST_PAUSED;
        end
      end

      ST_DOWN: begin
        if (w_expire) begin
          w_nextState = ST_ERR;
        end else if (i_down_done) begin
          w_nextRound = w_roundInc;
          w_nextPhase = 1'b1;
          if (w_finalRound) begin
            w_nextPend  = 1'b0;
            w_nextState = ST_IDLE;
          end else if (i_pause_pulse) begin
            w_nextPend  = 1'b1;
            w_nextState = ST_PAUSED;
          end else begin
            w_upStart   = 1'b1;
            w_nextState = ST_UP;
          end
        end else if (i_pause_pulse) begin
          w_nextState = ST_PAUSED;
        end
      end

      ST_PAUSED: begin
        // A counter that ignores hold may still finish its phase. Record
        // the phase change and owe the next start.
        if (r_phase && i_up_done) begin
          w_nextPhase = 1'b0;
          w_nextPend  = 1'b1;
        end else if (!r_phase && i_down_done) begin
          w_nextRound = w_roundInc;
          w_nextPhase = 1'b1;
          if (w_finalRound) begin
            w_nextPend  = 1'b0;
            w_nextState = ST_IDLE;
          end else begin
            w_nextPend  = 1'b1;
          end
        end

        // Releasing the pause resumes the current phase and pays any owed
        // start. A run that just ended drops the pause.
        if (i_pause_pulse && (w_nextState == ST_PAUSED)) begin
          if (w_nextPend) begin
            if (w_nextPhase) begin
              w_upStart = 1'b1;
            end else begin
              w_downStart = 1'b1;
            end
            w_nextPend = 1'b0;
          end
          w_nextState = w_nextPhase ? ST_UP : ST_DOWN;
        end
      end

`ifdef COUNT_SEQ_WATCHDOG_EN
      ST_ERR: begin
        if (i_go_pulse) begin
          w_nextPhase = 1'b1;
          w_nextPend  = 1'b0;
          w_nextState = ST_IDLE;
        end
      end
`endif

      default: begin
        w_nextPhase = 1'b1;
        w_nextPend  = 1'b0;
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // FSM state and internal bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_phase <= 1'b1;
      r_pend  <= 1'b0;
      r_round <= '0;
    end else begin
      r_state <= w_nextState;
      r_phase <= w_nextPhase;
      r_pend  <= w_nextPend;
      r_round <= w_nextRound;
    end
  end

`ifdef COUNT_SEQ_WATCHDOG_EN
  assign w_holdNext = (w_nextState == ST_PAUSED) || (w_nextState == ST_ERR);
`else
  assign w_holdNext = (w_nextState == ST_PAUSED);
`endif

  // Registered outputs. Start pulses land one cycle after their cause, and
  // status flags follow the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_up_start   <= 1'b0;
      o_down_start <= 1'b0;
      o_hold       <= 1'b0;
      o_busy       <= 1'b0;
      o_paused     <= 1'b0;
    end else begin
      o_up_start   <= w_upStart;
      o_down_start <= w_downStart;
      o_hold       <= w_holdNext;
      o_busy       <= (w_nextState != ST_IDLE);
      o_paused     <= (w_nextState == ST_PAUSED);
    end
  end

`ifdef COUNT_SEQ_WATCHDOG_EN
  // The watchdog fault flag is raised on entry to ERR and cleared on the way out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_err <= 1'b0;
    end else begin
      o_err <= (w_nextState == ST_ERR);
    end
  end
`else
  assign o_err = 1'b0;
`endif

  assign o_led_sel   = r_phase;
  assign o_round_cnt = r_round;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer (ROUNDS=2, WD_TICKS=4).
// Each step drives one cycle of pulses and queues the expected registered
// outputs. The entry is popped and compared just after the clock edge.
// The watchdog scenario runs when COUNT_SEQ_WATCHDOG_EN is defined.
module tb_count_sequencer;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       goPulse;
  logic       pausePulse;
  logic       upDone;
  logic       downDone;
  logic       upStart;
  logic       downStart;
  logic       hold;
  logic       ledSel;
  logic       busy;
  logic       paused;
  logic [7:0] roundCnt;
  logic       err;

  int totalChecks = 0;
  int badChecks   = 0;

  // Expected output entry: {upS, downS, hold, led, busy, paused, err}, round.
  typedef struct packed {
    logic [6:0] flags;
    logic [7:0] rnd;
  } exp_t;

  exp_t expQ[$];

  count_sequencer #(
    .ROUNDS   (2),
    .ROUND_W  (8),
    .WD_TICKS (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_tick        (tick),
    .i_go_pulse    (goPulse),
    .i_pause_pulse (pausePulse),
    .i_up_done     (upDone),
    .i_down_done   (downDone),
    .o_up_start    (upStart),
    .o_down_start  (downStart),
    .o_hold        (hold),
    .o_led_sel     (ledSel),
    .o_busy        (busy),
    .o_paused      (paused),
    .o_round_cnt   (roundCnt),
    .o_err         (err)
  );

  // 10 ns system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Compare every output against one expected entry.
  task automatic compareAll(input string tag, input exp_t e);
    checkOutput({tag, ".up_start"},   8'(upStart),   8'(e.flags[6]));
    checkOutput({tag, ".down_start"}, 8'(downStart), 8'(e.flags[5]));
    checkOutput({tag, ".hold"},       8'(hold),      8'(e.flags[4]));
    checkOutput({tag, ".led_sel"},    8'(ledSel),    8'(e.flags[3]));
    checkOutput({tag, ".busy"},       8'(busy),      8'(e.flags[2]));
    checkOutput({tag, ".paused"},     8'(paused),    8'(e.flags[1]));
    checkOutput({tag, ".err"},        8'(err),       8'(e.flags[0]));
    checkOutput({tag, ".round_cnt"},  roundCnt,      e.rnd);
  endtask

  // Drive one cycle of pulses {go, pause, upDone, downDone, tick}, queue the
  // expected result, then pop and compare after the edge.
  task automatic applyStimulus(input string tag, input logic [4:0] stim,
                               input logic [6:0] flags, input logic [7:0] rnd);
    exp_t e;
    goPulse    = stim[4];
    pausePulse = stim[3];
    upDone     = stim[2];
    downDone   = stim[1];
    tick       = stim[0];
    expQ.push_back({flags, rnd});
    @(posedge clk);
    #1;
    goPulse    = 1'b0;
    pausePulse = 1'b0;
    upDone     = 1'b0;
    downDone   = 1'b0;
    tick       = 1'b0;
    if (expQ.size() == 0) begin
      badChecks++;
      totalChecks++;
      $display("[TB] FAIL %s: scoreboard empty", tag);
    end else begin
      e = expQ.pop_front();
      compareAll(tag, e);
    end
  endtask

  initial begin
    rst        = 1'b1;
    goPulse    = 1'b0;
    pausePulse = 1'b0;
    upDone     = 1'b0;
    downDone   = 1'b0;
    tick       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compareAll("reset", {7'b0001000, 8'd0});
    @(negedge clk);
    rst = 1'b0;

    // Idle behaviour and a full two-round run.
    applyStimulus("idlePause",   5'b01000, 7'b0001000, 8'd0);
    applyStimulus("go",          5'b10000, 7'b1001100, 8'd0);
    applyStimulus("upWait",      5'b00000, 7'b0001100, 8'd0);
    applyStimulus("upDone1",     5'b00100, 7'b0100100, 8'd0);
    applyStimulus("downDone1",   5'b00010, 7'b1001100, 8'd1);
    applyStimulus("upDone2",     5'b00100, 7'b0100100, 8'd1);
    applyStimulus("downDone2",   5'b00010, 7'b0001000, 8'd2);
    applyStimulus("idleAfter",   5'b00000, 7'b0001000, 8'd2);

    // Go with pause together, plain pause/resume, done+pause deferral.
    applyStimulus("goAndPause",  5'b11000, 7'b1001100, 8'd0);
    applyStimulus("pauseUp",     5'b01000, 7'b0011110, 8'd0);
    applyStimulus("resumeUp",    5'b01000, 7'b0001100, 8'd0);
    applyStimulus("upDonePause", 5'b01100, 7'b0010110, 8'd0);
    applyStimulus("goInPause",   5'b10000, 7'b0010110, 8'd0);
    applyStimulus("resumeDown",  5'b01000, 7'b0100100, 8'd0);
    applyStimulus("dnDonePause", 5'b01010, 7'b0011110, 8'd1);
    applyStimulus("resumeUp2",   5'b01000, 7'b1001100, 8'd1);
    applyStimulus("upDone3",     5'b00100, 7'b0100100, 8'd1);
    applyStimulus("finalPause",  5'b01010, 7'b0001000, 8'd2);

    // A done arriving while paused is recorded and owed on resume.
    applyStimulus("go2",         5'b10000, 7'b1001100, 8'd0);
    applyStimulus("pause2",      5'b01000, 7'b0011110, 8'd0);
    applyStimulus("doneInPause", 5'b00100, 7'b0010110, 8'd0);
    applyStimulus("resumeOwed",  5'b01000, 7'b0100100, 8'd0);

    // Asynchronous reset mid-run clears everything at once.
    #2;
    rst = 1'b1;
    #1;
    compareAll("midReset", {7'b0001000, 8'd0});
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("postReset",   5'b00000, 7'b0001000, 8'd0);

`ifdef COUNT_SEQ_WATCHDOG_EN
    // Four ticks without a done trip the watchdog; go clears the fault.
    applyStimulus("wdGo",        5'b10000, 7'b1001100, 8'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("wdTick",    5'b00001, 7'b0001100, 8'd0);
    end
    applyStimulus("wdErr",       5'b00000, 7'b0011101, 8'd0);
    applyStimulus("wdErrPause",  5'b01000, 7'b0011101, 8'd0);
    applyStimulus("wdClear",     5'b10000, 7'b0001000, 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Central FSM that sequences the up/down counter pair: accepts debounced go/pause pulses, issues start pulses to each counter, holds them while paused, and selects which counter drives the LEDs.
- Replaces the ad-hoc glue (go gating, pause toggle, direction flag) in the top level.
- Runs entirely on clk. The divided clock is used only as a one-cycle-per-period enable (`tick`).

Parameters:
- ROUNDS, 0, number of full up+down rounds before returning to IDLE; 0 = run until reset.
- ROUND_W, 8, width of the round counter; must satisfy ROUNDS < 2**ROUND_W.
- WD_TICKS, 64, watchdog limit in ticks per phase (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle enable per divided period (watchdog time base)
- go_pulse  in  1  debounced one-cycle go request
- pause_pulse  in  1  debounced one-cycle pause-toggle request
- up_done  in  1  one-cycle pulse: up counter finished
- down_done  in  1  one-cycle pulse: down counter finished
- up_start  out  1  one-cycle start pulse to up counter
- down_start  out  1  one-cycle start pulse to down counter
- hold  out  1  freeze both counters (level)
- led_sel  out  1  1 = LEDs show up counter, 0 = LEDs show down counter
- busy  out  1  high when state != IDLE
- paused  out  1  high in PAUSED
- round_cnt  out  ROUND_W  completed rounds since the last go
- err  out  1  watchdog fault (optional feature; otherwise tied 0)

Behaviour:
- States are IDLE, UP, DOWN, PAUSED (plus ERR with the optional feature). Internal registers: `phase` (1 = up) and `pend` (deferred start owed).
- Reset values: state=IDLE, phase=1, pend=0, and every output 0 except led_sel=1.
- All outputs are registered, so each start pulse appears exactly 1 cycle after its cause and stays high for 1 cycle.
- IDLE:
  - go_pulse: up_start, round_cnt cleared to 0, go to UP.
  - pause_pulse is ignored.
  - go and pause in the same cycle: go is taken, pause is dropped.
- UP:
  - up_done: phase=0, down_start, go to DOWN.
  - pause_pulse alone: go to PAUSED.
- DOWN, on down_done:
  - round_cnt increments, wrapping modulo 2**ROUND_W.
  - If ROUNDS!=0 and the incremented value == ROUNDS: go to IDLE, phase=1, no start pulse issued.
  - Otherwise: phase=1, up_start, go to UP.
- DOWN, pause_pulse alone: go to PAUSED.
- done and pause in the same cycle (UP or DOWN):
  - The done is processed first: phase flips and round_cnt updates as above.
  - The start pulse is suppressed and pend=1; go to PAUSED.
  - If the final round completes in that cycle, go to IDLE instead and the pause is dropped.
- PAUSED:
  - hold=1.
  - pause_pulse: if pend, emit the start matching phase and clear pend; return to UP if phase=1, else DOWN.
  - A done arriving in PAUSED (counter not honouring hold) is treated as above, with pend=1 and the FSM staying in PAUSED.
  - go_pulse is ignored.
- led_sel = phase at all times; busy and paused are derived registered from the next state.
- Reset mid-operation returns everything to reset values in the same cycle, with no start pulse.

Optional Feature:
- Macro: COUNT_SEQ_WATCHDOG_EN.
- With the macro defined:
  - A tick counter clears on each start pulse and counts ticks while in UP or DOWN.
  - It is frozen in PAUSED.
  - On reaching WD_TICKS the FSM goes to ERR, with err=1 and hold=1.
  - In ERR, go_pulse returns to IDLE (err=0, phase=1); pause is ignored.
- Without the macro: no ERR state, err is tied 0 and tick is unused.

Decomposition:
- Shared package `count_seq_pkg`: state encoding localparams (IDLE=0, UP=1, DOWN=2, PAUSED=3, ERR=4) and the 3-bit state width.
- One natural sub-module, `seq_watchdog`: the tick counter with clear/enable/expire ports, instantiated only under COUNT_SEQ_WATCHDOG_EN.

Test Plan:
- Reset, then go_pulse → up_start high exactly 1 cycle later; busy=1, led_sel=1, round_cnt=0.
- ROUNDS=2: drive go, up_done, down_done, up_done, down_done → pulse sequence down_start, up_start, down_start, then none; round_cnt=2, busy=0, led_sel=1.
- In UP, pause_pulse → hold=1, paused=1. A second pause_pulse → hold=0, no start pulse emitted.
- up_done and pause_pulse in the same cycle → no down_start, led_sel=0, paused=1. Next pause_pulse → down_start 1 cycle later, state DOWN.
- In IDLE, pause_pulse alone → no change. go and pause together → up_start, paused=0.
- With COUNT_SEQ_WATCHDOG_EN and WD_TICKS=4: go, then 4 ticks with no up_done → err=1, hold=1. Then go_pulse → err=0, busy=0.
